// File: rtl/ram_dp_bec.sv
// ram_dp_bec: dual-port RAM, port A read/write with byte enables,
// port B read-only, with a sequencer that clears the array to INIT_VAL.
module ram_dp_bec #(
    parameter int              AW       = 7,
    parameter int              DW       = 16,
    parameter int              RDW_MODE = 0,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    output logic               busy,
    input  logic               a_en,
    input  logic               a_we,
    input  logic [DW/8-1:0]    a_be,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_din,
    output logic [DW-1:0]      a_dout,
    output logic               a_vld,
    input  logic               b_en,
    input  logic [AW-1:0]      b_addr,
    output logic [DW-1:0]      b_dout,
    output logic               b_vld
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;

    logic [DW-1:0] mem [DEPTH];

    logic          idle;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] be_mask;

    logic          a_rd;
    logic          b_rd;
    logic          b_hit;
    logic [DW-1:0] b_word;

    logic [DW-1:0] a_dout_d, a_dout_q;
    logic [DW-1:0] b_dout_d, b_dout_q;
    logic          a_vld_d,  a_vld_q;
    logic          b_vld_d,  b_vld_q;

    assign idle = (state_q == S_IDLE);

    // Clear sequencer: sweeps every address once, then hands the array back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {AW{1'b1}}) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Expand byte enables into a per-bit write mask.
    always_comb begin
        be_mask = '0;
        for (int k = 0; k < NB; k++) begin
            be_mask[8*k +: 8] = {8{a_be[k]}};
        end
    end

    // Single write path: the clearer owns it while busy, port A otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = a_addr;
        wr_data = a_din;
        wr_mask = be_mask;
        if (!idle) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = INIT_VAL;
            wr_mask = '1;
        end else if (a_en && a_we) begin
            wr_en   = 1'b1;
        end
    end

    // Merged word: enabled lanes take new data, the rest keep old data.
    always_comb begin
        wr_word = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Read-port next-state; requests are dropped while clearing.
    always_comb begin
        a_rd     = idle && a_en && !a_we;
        b_rd     = idle && b_en;
        b_hit    = (RDW_MODE != 0) && idle && wr_en &&
                   (wr_addr == b_addr);
        b_word   = b_hit ? wr_word : mem[b_addr];
        a_dout_d = a_rd ? mem[a_addr] : a_dout_q;
        b_dout_d = b_rd ? b_word : b_dout_q;
        a_vld_d  = a_rd;
        b_vld_d  = b_rd;
    end

    // Registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
        end else begin
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
        end
    end

    assign busy   = !idle;
    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;
    assign a_vld  = a_vld_q;
    assign b_vld  = b_vld_q;

endmodule

// File: tb/tb_ram_dp_bec.sv
// tb_ram_dp_bec: directed checks of ram_dp_bec in both
// read-during-write modes, driven from one shared stimulus.
module tb_ram_dp_bec;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        a_en;
    logic        a_we;
    logic [1:0]  a_be;
    logic [6:0]  a_addr;
    logic [15:0] a_din;
    logic [6:0]  b_addr;
    logic        b_en;

    logic        busy0, busy1;
    logic [15:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_vld0, a_vld1, b_vld0, b_vld1;

    int total = 0;
    int bad   = 0;
    int n;
    logic v;

    localparam logic [15:0] IV = 16'h5A5A;

    ram_dp_bec #(.AW(7), .DW(16), .RDW_MODE(0), .INIT_VAL(IV)) u0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_din(a_din), .a_dout(a_dout0), .a_vld(a_vld0),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0), .b_vld(b_vld0)
    );

    ram_dp_bec #(.AW(7), .DW(16), .RDW_MODE(1), .INIT_VAL(IV)) u1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_din(a_din), .a_dout(a_dout1), .a_vld(a_vld1),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1), .b_vld(b_vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        clr_req = 1'b0;
        a_en    = 1'b0;
        a_we    = 1'b0;
        a_be    = 2'b00;
        b_en    = 1'b0;
    endtask

    task automatic wr(input logic [6:0] ad, input logic [15:0] d,
                      input logic [1:0] be);
        idle_in();
        a_en = 1'b1; a_we = 1'b1;
        a_addr = ad; a_din = d; a_be = be;
        cyc();
        idle_in();
        chk("wr_avld", 32'(a_vld0), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] ad,
                          input logic [15:0] exp);
        idle_in();
        a_en = 1'b1; a_addr = ad;
        b_en = 1'b1; b_addr = ad;
        cyc();
        idle_in();
        chk({tag, "_avld"}, 32'(a_vld0), 32'd1);
        chk({tag, "_a"}, 32'(a_dout0), 32'(exp));
        chk({tag, "_bvld"}, 32'(b_vld0), 32'd1);
        chk({tag, "_b0"}, 32'(b_dout0), 32'(exp));
        chk({tag, "_b1"}, 32'(b_dout1), 32'(exp));
        cyc();
        chk({tag, "_avld_drop"}, 32'(a_vld0), 32'd0);
        chk({tag, "_a_hold"}, 32'(a_dout0), 32'(exp));
    endtask

    task automatic wait_idle(output int cnt, output logic seen);
        cnt  = 0;
        seen = 1'b0;
        while ((busy0 || busy1) && cnt < 400) begin
            cyc();
            cnt++;
            seen = seen | a_vld0 | b_vld0 | a_vld1 | b_vld1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_addr = '0; a_din = '0; b_addr = '0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_adout", 32'(a_dout0), 32'd0);
        chk("rst_bdout", 32'(b_dout0), 32'd0);
        chk("rst_avld", 32'(a_vld0), 32'd0);
        chk("rst_bvld", 32'(b_vld0), 32'd0);

        // power-on clear with reads requested throughout
        rst = 1'b0;
        a_en = 1'b1; a_we = 1'b0; b_en = 1'b1;
        wait_idle(n, v);
        idle_in();
        chk("init_len", 32'(n), 32'd128);
        chk("init_vld", 32'(v), 32'd0);
        chk("init_ahold", 32'(a_dout0), 32'd0);
        chk("init_bhold", 32'(b_dout0), 32'd0);

        rd_chk("init0", 7'd0, IV);
        rd_chk("init64", 7'd64, IV);
        rd_chk("init127", 7'd127, IV);

        // byte merge
        wr(7'd5, 16'hABCD, 2'b11);
        wr(7'd5, 16'h0012, 2'b01);
        rd_chk("merge", 7'd5, 16'hAB12);
        wr(7'd5, 16'hFFFF, 2'b00);
        rd_chk("be0", 7'd5, 16'hAB12);

        // collision
        wr(7'd9, 16'h1111, 2'b11);
        a_en = 1'b1; a_we = 1'b1; a_addr = 7'd9;
        a_din = 16'h2222; a_be = 2'b10;
        b_en = 1'b1; b_addr = 7'd9;
        cyc();
        idle_in();
        chk("col_bvld", 32'(b_vld0), 32'd1);
        chk("col_rf", 32'(b_dout0), 32'h1111);
        chk("col_wf", 32'(b_dout1), 32'h2211);
        b_en = 1'b1; b_addr = 7'd9;
        cyc();
        idle_in();
        chk("col_after0", 32'(b_dout0), 32'h2211);
        chk("col_after1", 32'(b_dout1), 32'h2211);

        // concurrent independent access
        a_en = 1'b1; a_we = 1'b1; a_addr = 7'd127;
        a_din = 16'h00FF; a_be = 2'b11;
        b_en = 1'b1; b_addr = 7'd0;
        cyc();
        idle_in();
        chk("conc_avld", 32'(a_vld0), 32'd0);
        chk("conc_b0", 32'(b_dout0), 32'(IV));
        chk("conc_b1", 32'(b_dout1), 32'(IV));
        a_en = 1'b1; a_addr = 7'd127;
        cyc();
        idle_in();
        chk("conc_a", 32'(a_dout0), 32'h00FF);

        // busy gating and ignored second request
        wr(7'd3, 16'hBEEF, 2'b11);
        clr_req = 1'b1;
        cyc();
        idle_in();
        chk("clr_busy", 32'(busy0), 32'd1);
        n = 0;
        v = 1'b0;
        while (busy0 && n < 400) begin
            n++;
            idle_in();
            a_addr = 7'd3; b_addr = 7'd3; b_en = 1'b1;
            if (n == 2) begin
                a_en = 1'b1; a_we = 1'b1;
                a_din = 16'h1234; a_be = 2'b11;
            end else if (n == 10) begin
                clr_req = 1'b1;
            end else begin
                a_en = 1'b1;
            end
            cyc();
            v = v | a_vld0 | b_vld0 | a_vld1 | b_vld1;
        end
        idle_in();
        chk("clr_len", 32'(n), 32'd128);
        chk("clr_vld", 32'(v), 32'd0);
        chk("clr_ahold", 32'(a_dout0), 32'h00FF);
        chk("clr_bhold0", 32'(b_dout0), 32'(IV));
        chk("clr_bhold1", 32'(b_dout1), 32'(IV));
        rd_chk("clr3", 7'd3, IV);

        // reset in the middle of a clear
        wr(7'd100, 16'h1234, 2'b11);
        rd_chk("pre100", 7'd100, 16'h1234);
        clr_req = 1'b1;
        cyc();
        idle_in();
        repeat (49) cyc();
        chk("mid_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'd1);
        chk("mid_rst_adout", 32'(a_dout0), 32'd0);
        rst = 1'b0;
        wait_idle(n, v);
        chk("mid_len", 32'(n), 32'd128);
        rd_chk("mid100", 7'd100, IV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_bec.md
Name: ram_dp_bec

Overview:
- Parametrised on-chip RAM: one read/write port (A) with byte enables, one independent read-only port (B).
- Memory contents are never reset directly. A clear sequencer writes INIT_VAL to every word, one word per clock.
  - It runs automatically after reset.
  - It also runs on request via clr_req.
- Port B read-during-write behaviour is selectable by parameter.
- Used as the general buffer/scratch memory for datapath blocks needing simultaneous write and read.

Parameters:
- AW, 7, address width; depth = 2**AW words.
- DW, 16, data width; must be a multiple of 8. NB = DW/8 byte lanes.
- RDW_MODE, 0, same-address read during a port A write: 0 = read-first (old data), 1 = write-first (new, byte-merged data).
- INIT_VAL, 0, DW-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  pulse: start a clear sequence.
- busy  out  1  high while the clear sequence runs.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write (1) / read (0); sampled with a_en.
- a_be  in  NB  port A byte enables; bit k controls data bits [8k+7:8k].
- a_addr  in  AW  port A address.
- a_din  in  DW  port A write data.
- a_dout  out  DW  port A read data (registered).
- a_vld  out  1  a_dout updated this cycle.
- b_en  in  1  port B read enable.
- b_addr  in  AW  port B address.
- b_dout  out  DW  port B read data (registered).
- b_vld  out  1  b_dout updated this cycle.

Behaviour:
- Reset (async, rst=1):
  - Outputs: a_dout=0, b_dout=0, a_vld=0, b_vld=0, busy=1.
  - Internal: state=CLEAR, clear counter=0.
  - Memory array is not touched by reset itself.
- FSM has two states, IDLE and CLEAR.
  - CLEAR: each cycle writes INIT_VAL to mem[cnt], then cnt+1. When cnt = 2**AW-1 is written, go to IDLE.
  - CLEAR lasts exactly 2**AW cycles after rst deasserts; busy=1 throughout.
  - busy drops on the edge that completes the last write.
  - IDLE: clr_req=1 at an edge → CLEAR with cnt=0; busy=1 from the following cycle.
  - clr_req while in CLEAR is ignored; it does not restart the sequence.
  - rst during CLEAR restarts the sequence from address 0.
- While busy=1, port A and port B requests are discarded:
  - no memory write;
  - a_vld = b_vld = 0;
  - a_dout and b_dout hold their values.
- Port A write (a_en=1, a_we=1, IDLE): at the edge, mem[a_addr] byte lane k ← a_din lane k where a_be[k]=1; other lanes unchanged.
  - a_be=0 is a legal no-op write.
  - a_vld=0 for writes.
- Port A read (a_en=1, a_we=0, IDLE): a_dout ← mem[a_addr] at the edge. a_vld=1 for the next cycle only. Latency is 1 clock.
- Port B read (b_en=1, IDLE): same as a port A read, on b_dout/b_vld. Ports A and B operate concurrently every cycle.
- Collision (port A write and port B read, same address, same edge):
  - RDW_MODE=0: b_dout = pre-write word.
  - RDW_MODE=1: b_dout = post-write word. Only enabled bytes take a_din; the rest keep their old value.
- No enable: the dout registers hold their value, vld=0.
- Addresses are full AW bits; all 2**AW locations are valid, with no out-of-range case. Clear counter wraps only via the FSM exit.
- The clear sequencer has exclusive write access to the array. It is a single write path muxed with port A.

Test Plan:
- Reset, AW=7, INIT_VAL=0x5A5A → busy=1 for exactly 128 cycles, then 0. Reading addr 0, 64 and 127 on both ports gives 0x5A5A, each with vld=1 one cycle after the request.
- Byte-merge: write addr 5 data 0xABCD be=11, then data 0x0012 be=01, then read addr 5 → a_dout=0xAB12. A write with be=00 leaves 0xAB12.
- Collision: mem[9]=0x1111; same edge, A writes 0x2222 be=10 to 9 and B reads 9.
  - RDW_MODE=0 → b_dout=0x1111.
  - RDW_MODE=1 → b_dout=0x2211.
  - The next B read returns 0x2211 in both modes.
- Busy gating: fill addr 3=0xBEEF, pulse clr_req, write addr 3=0x1234 on the second busy cycle.
  - a_vld/b_vld stay 0 throughout busy.
  - After busy falls, addr 3 reads INIT_VAL.
  - A second clr_req at cycle 10 of the clear does not extend busy beyond 128 cycles.
- Reset mid-clear: assert rst at clear cycle 50 for 2 cycles → busy stays 1, clear restarts at 0, busy falls 128 cycles after rst release.
- Concurrent independent access: A writes 0x00FF to addr 127 while B reads addr 0 → b_dout=INIT_VAL. Next cycle, A reads 127 → 0x00FF.
